// File: rtl/seq_umul_add.sv
// seq_umul_add: iterative radix-2 shift-add unsigned multiply-accumulate.
// Computes Product = Multiplicand * Multiplier + Addend and consumes one
// Multiplier bit per clock. A WIDTH-bit operation takes WIDTH RUN cycles.
module seq_umul_add #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     Multiplicand,
   input  logic [WIDTH-1:0]     Multiplier,
   input  logic [WIDTH-1:0]     Addend,
   output logic [2*WIDTH-1:0]   Product,
   output logic                 busy,
   output logic                 done
);

   // Counter just wide enough to reach WIDTH-1.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t              state_reg;
   state_t              state_next;
   logic [WIDTH-1:0]    mcand_reg;
   logic [WIDTH:0]      hi_reg;
   logic [WIDTH-1:0]    lo_reg;
   logic [CW-1:0]       count_reg;
   logic [2*WIDTH-1:0]  product_reg;
   logic                busy_reg;
   logic                done_reg;

   logic                accept;
   logic                last_iter;
   logic [WIDTH:0]      sum;
   logic [2*WIDTH:0]    shifted;

   // Next-state logic: accept a request in IDLE, leave RUN on the last iteration.
   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      last_iter  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (count_reg == LAST_COUNT) begin
               last_iter  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // One shift-add step: conditionally add the multiplicand into the upper half,
   // then shift the whole {hi,lo} pair right so the next multiplier bit lands in lo[0].
   always_comb begin
      sum     = hi_reg + (lo_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
      shifted = {sum, lo_reg} >> 1;
   end

   // State, datapath and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         mcand_reg   <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         count_reg   <= '0;
         product_reg <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         busy_reg  <= (state_next == RUN);
         done_reg  <= last_iter;
         if (accept) begin
            // Addend seeds the upper accumulator so it is summed in for free.
            mcand_reg <= Multiplicand;
            hi_reg    <= {1'b0, Addend};
            lo_reg    <= Multiplier;
            count_reg <= '0;
         end else if (state_reg == RUN) begin
            hi_reg    <= shifted[2*WIDTH:WIDTH];
            lo_reg    <= shifted[WIDTH-1:0];
            count_reg <= count_reg + 1'b1;
            // The top accumulator bit is always zero after the final shift.
            if (last_iter) begin
               product_reg <= shifted[2*WIDTH-1:0];
            end
         end
      end
   end

   assign Product = product_reg;
   assign busy    = busy_reg;
   assign done    = done_reg;

endmodule

// File: tb/tb_seq_umul_add.sv
// Testbench for seq_umul_add: random and directed stimulus, a cycle-level
// reference model, and a queue-based scoreboard checked by a separate monitor.
module tb_seq_umul_add;

   localparam int W   = 32;
   localparam int CLK = 10;

   logic           clk;
   logic           rst;
   logic           start;
   logic [W-1:0]   a_in;
   logic [W-1:0]   b_in;
   logic [W-1:0]   c_in;
   logic [2*W-1:0] Product;
   logic           busy;
   logic           done;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model state
   logic           model_on    = 1'b0;
   int             remaining   = 0;
   logic [2*W-1:0] pending     = '0;
   logic           exp_busy    = 1'b0;
   logic           exp_done    = 1'b0;
   logic [2*W-1:0] exp_product = '0;
   logic [2*W-1:0] exp_q[$];

   seq_umul_add #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .Multiplicand (a_in),
      .Multiplier   (b_in),
      .Addend       (c_in),
      .Product      (Product),
      .busy         (busy),
      .done         (done)
   );

   initial begin
      clk = 1'b0;
      forever #(CLK/2) clk = ~clk;
   end

   initial begin
      #(CLK * 60000);
      $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   // Behavioural model: an operation accepted while idle completes exactly
   // W edges later with A*B+C; a reset discards everything.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         model_on    = 1'b1;
         remaining   = 0;
         exp_busy    = 1'b0;
         exp_done    = 1'b0;
         exp_product = '0;
         exp_q.delete();
      end else begin
         exp_done = 1'b0;
         if (remaining > 0) begin
            remaining = remaining - 1;
            if (remaining == 0) begin
               exp_done    = 1'b1;
               exp_product = pending;
            end
         end else if (start) begin
            pending   = {{W{1'b0}}, a_in} * {{W{1'b0}}, b_in} + {{W{1'b0}}, c_in};
            remaining = W;
            exp_q.push_back(pending);
         end
         exp_busy = (remaining > 0);
      end
   end

   // Monitor: compare outputs against the model every cycle and pop the
   // scoreboard whenever the DUT signals done.
   logic [2*W-1:0] popped;
   always @(negedge clk) begin
      if (model_on) begin
         checks = checks + 1;
         if (busy !== exp_busy) begin
            errors = errors + 1;
            $display("FAIL busy cyc=%0d got=%b expected=%b", cyc, busy, exp_busy);
         end
         checks = checks + 1;
         if (done !== exp_done) begin
            errors = errors + 1;
            $display("FAIL done cyc=%0d got=%b expected=%b", cyc, done, exp_done);
         end
         checks = checks + 1;
         if (Product !== exp_product) begin
            errors = errors + 1;
            $display("FAIL product_hold cyc=%0d got=%h expected=%h", cyc, Product, exp_product);
         end
         if (done === 1'b1) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
               errors = errors + 1;
               $display("FAIL unexpected_done cyc=%0d got Product=%h expected no completion", cyc, Product);
            end else begin
               popped = exp_q.pop_front();
               if (Product !== popped) begin
                  errors = errors + 1;
                  $display("FAIL result cyc=%0d got=%h expected=%h", cyc, Product, popped);
               end else begin
                  $display("txn cyc=%0d Product=%h ok", cyc, Product);
               end
            end
         end
      end
   end

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
      a_in  = a;
      b_in  = b;
      c_in  = c;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait for done with a cycle budget; an expired budget is a failed check.
   task automatic wait_done(input int budget, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checks = checks + 1;
      if (!seen) begin
         errors = errors + 1;
         $display("FAIL timeout_%s cyc=%0d got no done expected done within %0d cycles", tag, cyc, budget);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      a_in  = '0;
      b_in  = '0;
      c_in  = '0;

      // Reset, then idle
      idle_cycles(2);
      rst = 1'b0;
      idle_cycles(10);

      // Basic multiply
      issue(32'd7, 32'd6, 32'd0);
      wait_done(W + 4, "basic");
      idle_cycles(4);

      // Divider-inverse style operands
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(W + 4, "maxval");
      issue(32'h0000_1234, 32'h0001_0003, 32'h0000_FFFF);
      wait_done(W + 4, "divinv");
      idle_cycles(2);

      // Ignored start and operand churn mid-run
      issue(32'd3, 32'd5, 32'd1);
      idle_cycles(5);
      for (int i = 0; i < 6; i++) begin
         a_in  = $urandom;
         b_in  = $urandom;
         c_in  = $urandom;
         start = (i == 2);
         @(negedge clk);
      end
      start = 1'b0;
      wait_done(W + 4, "ignored");
      idle_cycles(W + 4);

      // Reset mid-operation
      issue(32'h0000_FFFF, 32'h0000_FFFF, 32'd0);
      idle_cycles(9);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle_cycles(W + 4);
      issue(32'd2, 32'd3, 32'd4);
      wait_done(W + 4, "after_reset");
      idle_cycles(3);

      // Back-to-back with start held high
      a_in  = 32'd2;
      b_in  = 32'd3;
      c_in  = 32'd0;
      start = 1'b1;
      @(negedge clk);
      wait_done(W + 4, "b2b_first");
      a_in = 32'd0;
      b_in = 32'd9;
      c_in = 32'd5;
      wait_done(W + 4, "b2b_second");
      start = 1'b0;
      idle_cycles(W + 4);

      // Random operations with random gaps and mid-run operand churn
      for (int n = 0; n < 20; n++) begin
         issue($urandom, $urandom, $urandom);
         for (int k = 0; k < int'($urandom_range(W + 8, 4)); k++) begin
            a_in  = $urandom;
            b_in  = $urandom;
            c_in  = $urandom;
            start = ($urandom_range(7, 0) == 0);
            @(negedge clk);
         end
         start = 1'b0;
         idle_cycles(int'($urandom_range(W + 2, 0)));
      end
      idle_cycles(W + 4);

      // Every accepted operation must have completed
      checks = checks + 1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain got=%0d pending expected=0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
